// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Definitions shared by the APB requester FSM and completers:
//               transfer state encoding, default bus widths and the
//               word-alignment mask used for error checking.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Transfer phase seen by a completer
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 8;

  // Byte-offset bits that must be zero for a word-aligned access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_counter
// Description : Wait-state down-counter. Loaded with LOAD_VAL when a transfer
//               is set up, counts down once per access cycle, and flags zero
//               when the transfer may complete.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_counter #(
  parameter int CNT_W    = 1,
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,   // asynchronous, active-low
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the count saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Zero flag straight from the register: no path from the bus inputs
  assign zero = (cnt_q == '0);

endmodule : apb_wait_counter
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : APB completer with NREG word registers, WAIT_STATES wait
//               cycles per transfer and an error response for misaligned or
//               out-of-range addresses. Outputs are decoded from registered
//               state only.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int NREG        = 8,
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,      // asynchronous, active-low
  input  logic              pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  apb_state_e        state_q, state_d;
  // Only the word-index bits of the address are kept; the remaining bits
  // have already been folded into err_q at setup.
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              wr_q,    wr_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic setup;
  logic cnt_zero;
  logic commit;
  logic misaligned;
  logic out_of_range;

  // A setup is only recognised from IDLE; penable=1 in IDLE is ignored
  assign setup        = (state_q == ST_IDLE) && pselx && !penable;
  assign misaligned   = (paddr[1:0] & ALIGN_MASK) != 2'b00;
  assign out_of_range = paddr[ADDR_W-1:2] >= (ADDR_W-2)'(NREG);
  // A write lands only on a completing cycle that was not aborted
  assign commit       = (state_q == ST_ACCESS) && cnt_zero && pselx && wr_q && !err_q;

  apb_wait_counter #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (WAIT_STATES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .load (setup),
    .dec  (state_q == ST_ACCESS),
    .zero (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave ACCESS on completion or when the requester deselects
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!pselx || cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    pready  = (state_q == ST_ACCESS) && cnt_zero;
    pslverr = pready && err_q;
    prdata  = '0;
    if (pready && !wr_q && !err_q) begin
      prdata = regs_q[idx_q];
    end
  end

  // Capture the transfer attributes at setup; held through ACCESS
  always_comb begin
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    if (setup) begin
      idx_d   = paddr[IDX_W+1:2];
      wr_d    = pwrite;
      err_d   = misaligned || out_of_range;
      wdata_d = pwdata;
    end
  end

  // Transfer attribute registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  // One register per word; each updates only on its own committed write
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      always_comb begin
        regs_d[gi] = regs_q[gi];
        if (commit && (idx_q == IDX_W'(gi))) begin
          regs_d[gi] = wdata_q;
        end
      end

      // Register storage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

endmodule : apb_slave_regfile
`default_nettype wire
